// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
        logic [NUM_LANES-1:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first requesting lane at or after i_ptr (mod 4).
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [LANE_W-1:0]    i_ptr,
    output logic                 o_any,
    output logic [LANE_W-1:0]    o_idx
);

    logic [NUM_LANES-1:0] w_rot;
    logic [LANE_W-1:0]    w_off;

    // w_rot[k] is the request of lane ptr+k, so bit 0 has the highest priority
    always_comb begin
        w_rot = 4'b0000;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_rot[k] = i_req[i_ptr + LANE_W'(k)];
        end
    end

    // Offset of the lowest set bit in the rotated request vector
    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign o_any = |i_req;
    assign o_idx = i_ptr + w_off;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 data mux.
// Defining RR_ARB_TIMEOUT_EN caps each ownership at MAX_HOLD cycles.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_LANES-1:0]       req,
    input  logic [NUM_LANES*WIDTH-1:0] data_in,
    output logic [NUM_LANES-1:0]       grant,
    output logic [LANE_W-1:0]          sel,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid
);

    arb_state_e        r_fsm;
    arb_state_e        w_fsm_nxt;
    logic [LANE_W-1:0] r_owner;
    logic [LANE_W-1:0] w_owner_nxt;
    logic [LANE_W-1:0] r_ptr;
    logic [LANE_W-1:0] w_ptr_nxt;
    logic [LANE_W-1:0] w_pick_ptr;
    logic [LANE_W-1:0] w_pick_idx;
    logic              w_any;
    logic              w_hold_ok;
    logic              w_retain;
    logic [WIDTH-1:0]  w_pair_lo;
    logic [WIDTH-1:0]  w_pair_hi;
    logic [WIDTH-1:0]  w_mux;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;

    assign w_hold_ok = (r_hold_cnt < HOLD_W'(MAX_HOLD - 1));

    // Hold counter advances only on retained cycles; every new ownership restarts it
    always_comb begin
        w_hold_nxt = {HOLD_W{1'b0}};
        if ((r_fsm == GRANT) && w_retain) begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end else begin
            w_hold_nxt = {HOLD_W{1'b0}};
        end
    end

    // Hold counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_hold_cnt <= {HOLD_W{1'b0}};
        end else begin
            r_hold_cnt <= w_hold_nxt;
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;

    assign w_hold_ok = 1'b1;
`endif

    // While granted, the next candidate is searched from just past the owner
    assign w_pick_ptr = (r_fsm == GRANT) ? (r_owner + 2'd1) : r_ptr;
    assign w_retain   = req[r_owner] & w_hold_ok;

    rr_pick u_pick (
        .i_req (req),
        .i_ptr (w_pick_ptr),
        .o_any (w_any),
        .o_idx (w_pick_idx)
    );

    // Arbitration state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fsm   <= IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state: claim from idle, retain, or hand over back-to-back on release
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_fsm)
            IDLE: begin
                if (w_any) begin
                    w_fsm_nxt   = GRANT;
                    w_owner_nxt = w_pick_idx;
                end else begin
                    w_fsm_nxt   = IDLE;
                end
            end
            GRANT: begin
                if (w_retain) begin
                    w_fsm_nxt = GRANT;
                end else begin
                    w_ptr_nxt = r_owner + 2'd1;
                    if (w_any) begin
                        w_fsm_nxt   = GRANT;
                        w_owner_nxt = w_pick_idx;
                    end else begin
                        w_fsm_nxt   = IDLE;
                    end
                end
            end
            default: begin
                w_fsm_nxt   = IDLE;
                w_owner_nxt = 2'd0;
                w_ptr_nxt   = 2'd0;
            end
        endcase
    end

    assign valid = (r_fsm == GRANT);
    assign grant = valid ? lane_onehot(r_owner) : 4'b0000;
    assign sel   = valid ? r_owner : 2'b00;

    // sel[0] chooses within each lane pair, sel[1] chooses between pairs
    assign w_pair_lo = sel[0] ? data_in[1*WIDTH +: WIDTH] : data_in[0*WIDTH +: WIDTH];
    assign w_pair_hi = sel[0] ? data_in[3*WIDTH +: WIDTH] : data_in[2*WIDTH +: WIDTH];
    assign w_mux     = sel[1] ? w_pair_hi : w_pair_lo;
    assign data_out  = valid ? w_mux : {WIDTH{1'b0}};

endmodule
